// File: rtl/tage_tables.sv
// tage_tables: storage for the TAGE branch predictor.
// Holds one untagged bimodal base table (T0) of 2-bit counters and NUM_TAGGED
// tagged tables (T1..Tn). Each tagged entry has a tag, a 3-bit prediction counter
// and a 2-bit useful counter. Reads are combinational from the externally hashed
// indexes and tags. Writes happen at the rising clock edge.
// Optional feature macro: TAGE_TAG_VALID_EN. When it is defined, each tagged entry
// carries a valid bit that allocation sets and reset clears. A hit then needs
// both a set valid bit and a matching tag.
module tage_tables #(
   parameter int BHT_IDX_WIDTH  = 12,
   parameter int TAGE_IDX_WIDTH = 9,
   parameter int TAG_WIDTH      = 9,
   parameter int NUM_TAGGED     = 4
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 br_result_i,
   input  logic                                 bht_update_en_i,
   input  logic [BHT_IDX_WIDTH-1:0]             bht_idx_i,
   output logic                                 bht_pred_o,
   input  logic [NUM_TAGGED*TAGE_IDX_WIDTH-1:0] hash_idx_i,
   input  logic [NUM_TAGGED*TAG_WIDTH-1:0]      hash_tag_i,
   input  logic [NUM_TAGGED-1:0]                provider_i,
   input  logic                                 update_u_i,
   input  logic [NUM_TAGGED-1:0]                dec_u_i,
   input  logic [NUM_TAGGED-1:0]                alloc_i,
   output logic [NUM_TAGGED-1:0]                pred_o,
   output logic [NUM_TAGGED-1:0]                tag_hit_o,
   output logic [NUM_TAGGED-1:0]                new_entry_o,
   output logic [NUM_TAGGED*2-1:0]              u_o
);

   localparam int BHT_ENTRIES  = 1 << BHT_IDX_WIDTH;
   localparam int TAGE_ENTRIES = 1 << TAGE_IDX_WIDTH;

   // Saturating helpers for the 2-bit and 3-bit counters
   function automatic logic [1:0] sat2_inc(input logic [1:0] v);
      if (v == 2'd3) begin
         return 2'd3;
      end else begin
         return v + 2'd1;
      end
   endfunction

   function automatic logic [1:0] sat2_dec(input logic [1:0] v);
      if (v == 2'd0) begin
         return 2'd0;
      end else begin
         return v - 2'd1;
      end
   endfunction

   function automatic logic [2:0] sat3_step(input logic [2:0] v, input logic up);
      if (up) begin
         if (v == 3'd7) begin
            return 3'd7;
         end else begin
            return v + 3'd1;
         end
      end else begin
         if (v == 3'd0) begin
            return 3'd0;
         end else begin
            return v - 3'd1;
         end
      end
   endfunction

   // ---------------------------------------------------------------------
   // Base bimodal table
   // ---------------------------------------------------------------------
   logic [1:0] bht_ctr_r [BHT_ENTRIES];
   logic [1:0] bht_rd_s;
   logic [1:0] bht_nxt_s;

   assign bht_rd_s   = bht_ctr_r[bht_idx_i];
   assign bht_pred_o = bht_rd_s[1];

   // Next base counter value: move toward the resolved outcome
   always_comb begin
      bht_nxt_s = bht_rd_s;
      if (br_result_i) begin
         bht_nxt_s = sat2_inc(bht_rd_s);
      end else begin
         bht_nxt_s = sat2_dec(bht_rd_s);
      end
   end

   // Base table storage: reset to weak not-taken, otherwise write on update enable
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < BHT_ENTRIES; i++) begin
            bht_ctr_r[i] <= 2'd1;
         end
      end else if (bht_update_en_i) begin
         bht_ctr_r[bht_idx_i] <= bht_nxt_s;
      end
   end

   // ---------------------------------------------------------------------
   // Tagged tables
   // ---------------------------------------------------------------------
   for (genvar k = 0; k < NUM_TAGGED; k++) begin : g_tbl
      logic [TAG_WIDTH-1:0]      tag_r [TAGE_ENTRIES];
      logic [2:0]                ctr_r [TAGE_ENTRIES];
      logic [1:0]                u_r   [TAGE_ENTRIES];

      logic [TAGE_IDX_WIDTH-1:0] idx_s;
      logic [TAG_WIDTH-1:0]      lookup_tag_s;
      logic [TAG_WIDTH-1:0]      rd_tag_s;
      logic [TAG_WIDTH-1:0]      nxt_tag_s;
      logic [2:0]                rd_ctr_s;
      logic [2:0]                nxt_ctr_s;
      logic [1:0]                rd_u_s;
      logic [1:0]                nxt_u_s;
      logic                      wr_en_s;
      logic                      hit_s;

      assign idx_s        = hash_idx_i[k*TAGE_IDX_WIDTH +: TAGE_IDX_WIDTH];
      assign lookup_tag_s = hash_tag_i[k*TAG_WIDTH +: TAG_WIDTH];
      assign rd_tag_s     = tag_r[idx_s];
      assign rd_ctr_s     = ctr_r[idx_s];
      assign rd_u_s       = u_r[idx_s];

`ifdef TAGE_TAG_VALID_EN
      logic valid_r [TAGE_ENTRIES];
      logic rd_valid_s;

      assign rd_valid_s = valid_r[idx_s];
      assign hit_s      = rd_valid_s && (rd_tag_s == lookup_tag_s);

      // Valid bits: cleared by reset, set by allocation, otherwise held
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int i = 0; i < TAGE_ENTRIES; i++) begin
               valid_r[i] <= 1'b0;
            end
         end else if (alloc_i[k]) begin
            valid_r[idx_s] <= 1'b1;
         end
      end
`else
      assign hit_s = (rd_tag_s == lookup_tag_s);
`endif

      assign pred_o[k]      = rd_ctr_s[2];
      assign tag_hit_o[k]   = hit_s;
      assign new_entry_o[k] = (rd_u_s == 2'd0) && ((rd_ctr_s == 3'd3) || (rd_ctr_s == 3'd4));
      assign u_o[2*k +: 2]  = rd_u_s;

      // Allocation replaces the tag, so it is the only source of a new tag
      assign nxt_tag_s = alloc_i[k] ? lookup_tag_s : rd_tag_s;

      // An entry is rewritten only when one of the updating controls targets it
      assign wr_en_s = alloc_i[k] | provider_i[k] | dec_u_i[k];

      // Next prediction counter: allocation seeds it weakly; otherwise the provider trains it
      always_comb begin
         nxt_ctr_s = rd_ctr_s;
         if (alloc_i[k]) begin
            nxt_ctr_s = br_result_i ? 3'd4 : 3'd3;
         end else if (provider_i[k]) begin
            nxt_ctr_s = sat3_step(rd_ctr_s, br_result_i);
         end else begin
            nxt_ctr_s = rd_ctr_s;
         end
      end

      // Next useful counter: allocation clears it, an explicit decrement wins over training
      always_comb begin
         nxt_u_s = rd_u_s;
         if (alloc_i[k]) begin
            nxt_u_s = 2'd0;
         end else if (dec_u_i[k]) begin
            nxt_u_s = sat2_dec(rd_u_s);
         end else if (provider_i[k] && update_u_i) begin
            if (rd_ctr_s[2] == br_result_i) begin
               nxt_u_s = sat2_inc(rd_u_s);
            end else begin
               nxt_u_s = sat2_dec(rd_u_s);
            end
         end else begin
            nxt_u_s = rd_u_s;
         end
      end

      // Tagged entry storage: reset wins over every update, else write the selected entry
      always_ff @(posedge clk_i) begin
         if (rst_i) begin
            for (int i = 0; i < TAGE_ENTRIES; i++) begin
               tag_r[i] <= '0;
               ctr_r[i] <= 3'd3;
               u_r[i]   <= 2'd0;
            end
         end else if (wr_en_s) begin
            tag_r[idx_s] <= nxt_tag_s;
            ctr_r[idx_s] <= nxt_ctr_s;
            u_r[idx_s]   <= nxt_u_s;
         end
      end
   end

endmodule

// File: tb/tb_tage_tables.sv
// Self-checking bench for tage_tables. A table of vectors gives the inputs for
// each cycle and the outputs expected during that cycle, before that cycle's
// write. The expected values are pushed to a scoreboard queue when the inputs
// are driven. They are popped and compared once the combinational outputs have
// settled, ahead of the next rising edge.
module tb_tage_tables;

   logic        clk;
   logic        rst;
   logic        br;
   logic        bht_en;
   logic [11:0] bht_idx;
   logic        bht_pred;
   logic [35:0] hash_idx;
   logic [35:0] hash_tag;
   logic [3:0]  provider;
   logic        update_u;
   logic [3:0]  dec_u;
   logic [3:0]  alloc;
   logic [3:0]  pred;
   logic [3:0]  tag_hit;
   logic [3:0]  new_entry;
   logic [7:0]  u;

   int tests = 0;
   int fails = 0;

`ifdef TAGE_TAG_VALID_EN
   localparam logic [3:0] HIT0 = 4'b0000;
`else
   localparam logic [3:0] HIT0 = 4'b1111;
`endif

   typedef struct {
      logic [95:0] name;
      logic        rst;
      logic        br;
      logic        bht_en;
      logic [11:0] bht_idx;
      logic [8:0]  idx;
      logic [8:0]  tag;
      logic [3:0]  prov;
      logic        upd_u;
      logic [3:0]  dec_u;
      logic [3:0]  alloc;
      logic        e_bht;
      logic [3:0]  e_pred;
      logic [3:0]  e_hit;
      logic [3:0]  e_new;
      logic [7:0]  e_u;
   } vec_t;

   typedef struct {
      logic [95:0] name;
      logic        bht;
      logic [3:0]  pred;
      logic [3:0]  hit;
      logic [3:0]  nw;
      logic [7:0]  u;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   tage_tables dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .br_result_i     (br),
      .bht_update_en_i (bht_en),
      .bht_idx_i       (bht_idx),
      .bht_pred_o      (bht_pred),
      .hash_idx_i      (hash_idx),
      .hash_tag_i      (hash_tag),
      .provider_i      (provider),
      .update_u_i      (update_u),
      .dec_u_i         (dec_u),
      .alloc_i         (alloc),
      .pred_o          (pred),
      .tag_hit_o       (tag_hit),
      .new_entry_o     (new_entry),
      .u_o             (u)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, got running expected done");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic [95:0] name, input logic r, input logic b,
                               input logic en, input logic [11:0] bi, input logic [8:0] ix,
                               input logic [8:0] tg, input logic [3:0] pv, input logic uu,
                               input logic [3:0] du, input logic [3:0] al, input logic eb,
                               input logic [3:0] ep, input logic [3:0] eh, input logic [3:0] en2,
                               input logic [7:0] eu);
      vec_t v;
      v.name = name; v.rst = r; v.br = b; v.bht_en = en; v.bht_idx = bi;
      v.idx = ix; v.tag = tg; v.prov = pv; v.upd_u = uu; v.dec_u = du; v.alloc = al;
      v.e_bht = eb; v.e_pred = ep; v.e_hit = eh; v.e_new = en2; v.e_u = eu;
      return v;
   endfunction

   task automatic check(input logic [95:0] row, input string field,
                        input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %0s.%0s: got %h expected %h", row, field, act, exp);
      end
   endtask

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $display("FAIL scoreboard: got empty queue expected an entry");
      end else begin
         e = sb.pop_front();
         check(e.name, "bht_pred",  {7'd0, bht_pred}, {7'd0, e.bht});
         check(e.name, "pred",      {4'd0, pred},      {4'd0, e.pred});
         check(e.name, "tag_hit",   {4'd0, tag_hit},   {4'd0, e.hit});
         check(e.name, "new_entry", {4'd0, new_entry}, {4'd0, e.nw});
         check(e.name, "u",         u,                 e.u);
      end
   endtask

   task automatic step(input vec_t v);
      exp_t e;
      @(negedge clk);
      rst      = v.rst;
      br       = v.br;
      bht_en   = v.bht_en;
      bht_idx  = v.bht_idx;
      hash_idx = {4{v.idx}};
      hash_tag = {4{v.tag}};
      provider = v.prov;
      update_u = v.upd_u;
      dec_u    = v.dec_u;
      alloc    = v.alloc;
      e.name = v.name; e.bht = v.e_bht; e.pred = v.e_pred;
      e.hit = v.e_hit; e.nw = v.e_new; e.u = v.e_u;
      sb.push_back(e);
      #2;
      compare_front();
   endtask

   initial begin
      rst = 1'b1; br = 1'b0; bht_en = 1'b0; bht_idx = 12'd0;
      hash_idx = 36'd0; hash_tag = 36'd0; provider = 4'd0; update_u = 1'b0;
      dec_u = 4'd0; alloc = 4'd0;

      //                 name           rst   br    en    bidx    idx     tag      prov     uu    dec      alloc    ebht  epred    ehit     enew     eu
      vecs.push_back(mk("rst_rd",      1'b0, 1'b0, 1'b0, 12'd5, 9'h000, 9'h1A5, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_t1",      1'b0, 1'b1, 1'b1, 12'd5, 9'h033, 9'h1A5, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_t2",      1'b0, 1'b1, 1'b1, 12'd5, 9'h033, 9'h1A5, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_t3",      1'b0, 1'b1, 1'b1, 12'd5, 9'h033, 9'h1A5, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_n1",      1'b0, 1'b0, 1'b1, 12'd5, 9'h033, 9'h1A5, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_n2",      1'b0, 1'b0, 1'b1, 12'd5, 9'h033, 9'h1A5, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("alloc",       1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0000, 1'b0, 4'b0000, 4'b0010, 1'b0, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("prov_t1",     1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1111, 8'h00));
      vecs.push_back(mk("prov_t2",     1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1101, 8'h04));
      vecs.push_back(mk("prov_t3",     1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1101, 8'h08));
      vecs.push_back(mk("prov_n1",     1'b0, 1'b0, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1101, 8'h0C));
      vecs.push_back(mk("prov_n2",     1'b0, 1'b0, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1101, 8'h08));
      vecs.push_back(mk("prov_n3",     1'b0, 1'b0, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1101, 8'h04));
      vecs.push_back(mk("prov_n4",     1'b0, 1'b0, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1111, 8'h00));
      vecs.push_back(mk("prov_w",      1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0010, 4'b1111, 8'h00));
      vecs.push_back(mk("prov_c1",     1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1111, 8'h00));
      vecs.push_back(mk("prov_c2",     1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1101, 8'h04));
      vecs.push_back(mk("dec_upd",     1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h1A5, 4'b0010, 1'b1, 4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b1101, 8'h08));
      vecs.push_back(mk("alloc_prov",  1'b0, 1'b0, 1'b0, 12'd5, 9'h033, 9'h0C3, 4'b0010, 1'b1, 4'b0000, 4'b0010, 1'b0, 4'b0010, 4'b0000, 4'b1101, 8'h04));
      vecs.push_back(mk("alloc_multi", 1'b0, 1'b1, 1'b0, 12'd5, 9'h033, 9'h0C3, 4'b0000, 1'b0, 4'b0000, 4'b1101, 1'b0, 4'b0000, 4'b0010, 4'b1111, 8'h00));
      vecs.push_back(mk("rst_mid",     1'b1, 1'b1, 1'b1, 12'd5, 9'h033, 9'h0C3, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b0, 4'b1101, 4'b1111, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_d1",      1'b0, 1'b0, 1'b1, 12'd5, 9'h033, 9'h0C3, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_d2",      1'b0, 1'b0, 1'b1, 12'd5, 9'h033, 9'h000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, HIT0,    4'b1111, 8'h00));
      vecs.push_back(mk("bht_i1",      1'b0, 1'b1, 1'b1, 12'd5, 9'h033, 9'h0C3, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_i2",      1'b0, 1'b1, 1'b1, 12'd5, 9'h033, 9'h0C3, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      vecs.push_back(mk("bht_chk",     1'b0, 1'b0, 1'b0, 12'd5, 9'h033, 9'h0C3, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 4'b1111, 8'h00));

      repeat (2) @(posedge clk);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i]);
      end

      // Hand sequence: an allocation at one index must not leak into a neighbouring index
      step(mk("iso_alloc",  1'b0, 1'b0, 1'b0, 12'd5, 9'h034, 9'h155, 4'b0000, 1'b0, 4'b0000, 4'b1000,
              1'b1, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      step(mk("iso_other",  1'b0, 1'b0, 1'b0, 12'd5, 9'h033, 9'h155, 4'b0000, 1'b0, 4'b0000, 4'b0000,
              1'b1, 4'b0000, 4'b0000, 4'b1111, 8'h00));
      step(mk("iso_same",   1'b0, 1'b0, 1'b0, 12'd5, 9'h034, 9'h155, 4'b0000, 1'b0, 4'b0000, 4'b0000,
              1'b1, 4'b0000, 4'b1000, 4'b1111, 8'h00));

      @(negedge clk);
      alloc = 4'd0; provider = 4'd0; dec_u = 4'd0; bht_en = 1'b0; update_u = 1'b0;

      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
